// File: rtl/ram_wr_pkg.sv
// ----------------------------------------------------------------------------
// ram_wr_pkg
// Shared definitions for the RAM write-side controller.
//   - wr_state_t : controller FSM states (IDLE, WRITE, DONE)
//   - DEF_DATA_W : default stream / RAM data width
//   - DEF_ADDR_W : default RAM address width (depth = 2^ADDR_W)
//   - clamp_len  : limits a requested frame length to the RAM depth
// ----------------------------------------------------------------------------
package ram_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Returns min(len_v, 2^addr_w). A frame can never be longer than the
    // RAM, otherwise it would overwrite its own first words.
    function automatic logic [31:0] clamp_len(input logic [31:0] len_v,
                                              input int unsigned addr_w);
        logic [31:0] depth_v;
        depth_v = 32'd1 << addr_w;
        if (len_v > depth_v) begin
            return depth_v;
        end else begin
            return len_v;
        end
    endfunction

endpackage : ram_wr_pkg

// File: rtl/ram_wr_ctrl.sv
// ----------------------------------------------------------------------------
// ram_wr_ctrl
// Write-side controller placed directly upstream of dp_ram. Accepts a
// valid/ready word stream and packs one frame of 1..2^ADDR_W words into
// consecutive RAM addresses, driving the RAM write port from registers.
//
// Parameters
//   DATA_W   stream and RAM data width
//   ADDR_W   RAM address width (depth = 2^ADDR_W)
//
// Ports
//   w_clk    in   write clock (same clock as dp_ram.w_clk)
//   w_rst    in   asynchronous active-high reset
//   start    in   one-cycle frame request, only looked at in IDLE
//   len      in   frame length in words, sampled with start (0 = empty frame)
//   in_valid in   upstream word valid
//   in_data  in   upstream word
//   in_ready out  controller accepts a word this cycle (registered)
//   w_en     out  RAM write enable
//   w_addr   out  RAM write address
//   w_data   out  RAM write data
//   busy     out  frame in progress (cycle after start through DONE)
//   done     out  one-cycle pulse coinciding with the final write of a frame
//
// Build option
//   RAM_WR_CIRC_EN  when defined, each frame starts right after the last
//                   address written by the previous frame (circular buffer);
//                   otherwise every frame starts at address 0.
// ----------------------------------------------------------------------------
module ram_wr_ctrl
    import ram_wr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              done
);

    wr_state_t         state_r;
    logic [ADDR_W:0]   len_r;        // clamped frame length
    logic [ADDR_W:0]   cnt_r;        // words accepted so far in this frame
    logic [ADDR_W-1:0] addr_r;       // address for the next accepted word
    logic [ADDR_W-1:0] start_addr_r; // first address of the next frame

    logic              hs_s;         // stream handshake this cycle
    logic              last_word_s;  // handshake carries the final word

    assign hs_s        = in_valid & in_ready;
    assign last_word_s = (cnt_r == (len_r - (ADDR_W+1)'(1)));

    // Controller FSM together with all output and bookkeeping registers.
    // in_ready, busy and done are loaded from the next-state decision so
    // they are pure registered state decodes.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_r      <= ST_IDLE;
            len_r        <= '0;
            cnt_r        <= '0;
            addr_r       <= '0;
            start_addr_r <= '0;
            in_ready     <= 1'b0;
            w_en         <= 1'b0;
            w_addr       <= '0;
            w_data       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // A write strobe lasts one cycle unless a new handshake re-arms it;
            // w_addr / w_data keep their last values between writes.
            w_en <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        addr_r <= start_addr_r;
                        cnt_r  <= '0;
                        if (len != '0) begin
                            len_r    <= (ADDR_W+1)'(clamp_len(32'(len), ADDR_W));
                            in_ready <= 1'b1;
                            state_r  <= ST_WRITE;
                        end else begin
                            // Empty frame: report completion without writing.
                            len_r   <= '0;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    if (hs_s) begin
                        w_en   <= 1'b1;
                        w_addr <= addr_r;
                        w_data <= in_data;
                        addr_r <= addr_r + ADDR_W'(1); // wraps at 2^ADDR_W
                        cnt_r  <= cnt_r + (ADDR_W+1)'(1);
                        if (last_word_s) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r <= ST_WRITE;
                        end
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
`ifdef RAM_WR_CIRC_EN
                    // addr_r already points one past the last written word.
                    start_addr_r <= addr_r;
`else
                    start_addr_r <= '0;
`endif
                end

                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule : ram_wr_ctrl
